// File: rtl/lvds_mon_pkg.sv
// Shared definitions for the LVDS link error monitor: state encoding,
// default parameter values and a constant-width helper.
package lvds_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRAIN  = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAULT  = 2'd3
  } link_state_t;

  localparam int DEF_WIN_LEN        = 1024;
  localparam int DEF_ERR_THRESH     = 4;
  localparam int DEF_GOOD_WINS      = 8;
  localparam int DEF_BAD_WINS       = 2;
  localparam int DEF_MAX_TRAIN_WINS = 64;
  localparam int DEF_TOT_W          = 32;

  // Bits needed to index 'value' distinct items (ceil(log2(value))).
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/lvds_win_counter.sv
// Measurement window position counter and per-window error accumulator.
// Runs only while 'run' is high; dropping 'run' discards the partial window.
module lvds_win_counter
  import lvds_mon_pkg::*;
#(
  parameter int WIN_LEN = DEF_WIN_LEN
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            run,
  input  logic                            error_flag,
  output logic                            win_end,
  output logic [clog2(WIN_LEN + 1)-1:0]   win_sum,
  output logic [clog2(WIN_LEN + 1)-1:0]   win_err_cnt,
  output logic                            win_valid
);

  localparam int CW = clog2(WIN_LEN + 1);
  localparam int PW = clog2(WIN_LEN);
  localparam logic [PW-1:0] POS_LAST = PW'(WIN_LEN - 1);

  logic [PW-1:0] pos_reg, pos_next;
  logic [CW-1:0] acc_reg, acc_next;
  logic [CW-1:0] win_err_cnt_reg;
  logic          win_valid_reg;

  // win_sum already includes this cycle's flag, so the end cycle is counted.
  always_comb begin
    win_end  = run && (pos_reg == POS_LAST);
    win_sum  = acc_reg + CW'(run & error_flag);
    pos_next = '0;
    acc_next = '0;
    if (run && !win_end) begin
      pos_next = pos_reg + PW'(1);
      acc_next = win_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_reg         <= '0;
      acc_reg         <= '0;
      win_err_cnt_reg <= '0;
      win_valid_reg   <= 1'b0;
    end else begin
      pos_reg       <= pos_next;
      acc_reg       <= acc_next;
      win_valid_reg <= win_end;
      if (win_end) begin
        win_err_cnt_reg <= win_sum;
      end
    end
  end

  assign win_err_cnt = win_err_cnt_reg;
  assign win_valid   = win_valid_reg;

endmodule

// File: rtl/lvds_link_err_monitor.sv
// Lane qualification FSM (IDLE/TRAIN/LOCKED/FAULT) driven by windowed error
// counts, plus re-alignment request and saturating debug statistics.
module lvds_link_err_monitor
  import lvds_mon_pkg::*;
#(
  parameter int WIN_LEN        = DEF_WIN_LEN,
  parameter int ERR_THRESH     = DEF_ERR_THRESH,
  parameter int GOOD_WINS      = DEF_GOOD_WINS,
  parameter int BAD_WINS       = DEF_BAD_WINS,
  parameter int MAX_TRAIN_WINS = DEF_MAX_TRAIN_WINS,
  parameter int TOT_W          = DEF_TOT_W
) (
  input  logic                          I_clk,
  input  logic                          I_rst,
  input  logic                          I_lane_dpa_done,
  input  logic                          I_error_flag,
  input  logic                          I_clr_cnt,
  output logic                          O_link_ok,
  output logic                          O_realign_req,
  output logic [1:0]                    O_state,
  output logic                          O_win_valid,
  output logic [clog2(WIN_LEN + 1)-1:0] O_win_err_cnt,
  output logic [TOT_W-1:0]              O_err_total,
  output logic [7:0]                    O_realign_cnt
);

  localparam int CW = clog2(WIN_LEN + 1);
  localparam int GW = clog2(GOOD_WINS + 1);
  localparam int BW = clog2(BAD_WINS + 1);
  localparam int TW = clog2(MAX_TRAIN_WINS + 1);

  localparam logic [CW-1:0] ERR_LIM   = CW'(ERR_THRESH);
  localparam logic [GW-1:0] GOOD_LIM  = GW'(GOOD_WINS);
  localparam logic [BW-1:0] BAD_LIM   = BW'(BAD_WINS);
  localparam logic [TW-1:0] TRAIN_LIM = TW'(MAX_TRAIN_WINS);

  link_state_t     state_reg, state_next;
  logic [GW-1:0]   good_cnt_reg, good_cnt_next;
  logic [BW-1:0]   bad_cnt_reg, bad_cnt_next;
  logic [TW-1:0]   train_cnt_reg, train_cnt_next;
  logic            link_ok_reg;
  logic            realign_req_reg;
  logic [TOT_W-1:0] err_total_reg;
  logic [7:0]      realign_cnt_reg;

  logic            run;
  logic            win_end;
  logic            win_dirty;
  logic            fault_entry;
  logic [CW-1:0]   win_sum;

  assign run = I_lane_dpa_done &&
               ((state_reg == ST_TRAIN) || (state_reg == ST_LOCKED));

  lvds_win_counter #(
    .WIN_LEN(WIN_LEN)
  ) u_win (
    .clk        (I_clk),
    .rst_n      (I_rst),
    .run        (run),
    .error_flag (I_error_flag),
    .win_end    (win_end),
    .win_sum    (win_sum),
    .win_err_cnt(O_win_err_cnt),
    .win_valid  (O_win_valid)
  );

  assign win_dirty = (win_sum >= ERR_LIM);

  // Losing DPA always returns to IDLE first, ahead of any window verdict.
  always_comb begin
    state_next     = state_reg;
    good_cnt_next  = good_cnt_reg;
    bad_cnt_next   = bad_cnt_reg;
    train_cnt_next = train_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (I_lane_dpa_done) begin
          state_next     = ST_TRAIN;
          good_cnt_next  = '0;
          bad_cnt_next   = '0;
          train_cnt_next = '0;
        end
      end
      ST_TRAIN: begin
        if (!I_lane_dpa_done) begin
          state_next = ST_IDLE;
        end else if (win_end) begin
          train_cnt_next = train_cnt_reg + TW'(1);
          good_cnt_next  = win_dirty ? '0 : good_cnt_reg + GW'(1);
          // A lock earned on the last allowed window beats the timeout.
          if (!win_dirty && (good_cnt_next == GOOD_LIM)) begin
            state_next   = ST_LOCKED;
            bad_cnt_next = '0;
          end else if (train_cnt_next == TRAIN_LIM) begin
            state_next = ST_FAULT;
          end
        end
      end
      ST_LOCKED: begin
        if (!I_lane_dpa_done) begin
          state_next = ST_IDLE;
        end else if (win_end) begin
          if (win_dirty) begin
            bad_cnt_next = bad_cnt_reg + BW'(1);
            if (bad_cnt_next == BAD_LIM) begin
              state_next = ST_FAULT;
            end
          end else begin
            bad_cnt_next = '0;
          end
        end
      end
      default: begin
        if (!I_lane_dpa_done) begin
          state_next = ST_IDLE;
        end
      end
    endcase
  end

  assign fault_entry = (state_next == ST_FAULT) && (state_reg != ST_FAULT);

  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      state_reg       <= ST_IDLE;
      good_cnt_reg    <= '0;
      bad_cnt_reg     <= '0;
      train_cnt_reg   <= '0;
      link_ok_reg     <= 1'b0;
      realign_req_reg <= 1'b0;
      err_total_reg   <= '0;
      realign_cnt_reg <= '0;
    end else begin
      state_reg       <= state_next;
      good_cnt_reg    <= good_cnt_next;
      bad_cnt_reg     <= bad_cnt_next;
      train_cnt_reg   <= train_cnt_next;
      link_ok_reg     <= (state_next == ST_LOCKED);
      realign_req_reg <= fault_entry;
      // Clear wins over a same-cycle increment; that cycle's event is dropped.
      if (I_clr_cnt) begin
        err_total_reg   <= '0;
        realign_cnt_reg <= '0;
      end else begin
        if (I_error_flag && I_lane_dpa_done && (err_total_reg != '1)) begin
          err_total_reg <= err_total_reg + TOT_W'(1);
        end
        if (fault_entry && (realign_cnt_reg != 8'hFF)) begin
          realign_cnt_reg <= realign_cnt_reg + 8'd1;
        end
      end
    end
  end

  assign O_state       = state_reg;
  assign O_link_ok     = link_ok_reg;
  assign O_realign_req = realign_req_reg;
  assign O_err_total   = err_total_reg;
  assign O_realign_cnt = realign_cnt_reg;

endmodule

// File: tb/tb_lvds_link_err_monitor.sv
// Table-driven bench for lvds_link_err_monitor (WIN_LEN=16, ERR_THRESH=2,
// GOOD_WINS=3, BAD_WINS=2, MAX_TRAIN_WINS=8, TOT_W=4).
module tb_lvds_link_err_monitor;

  logic       I_clk = 1'b0;
  logic       I_rst = 1'b0;
  logic       I_lane_dpa_done = 1'b0;
  logic       I_error_flag = 1'b0;
  logic       I_clr_cnt = 1'b0;
  logic       O_link_ok;
  logic       O_realign_req;
  logic [1:0] O_state;
  logic       O_win_valid;
  logic [4:0] O_win_err_cnt;
  logic [3:0] O_err_total;
  logic [7:0] O_realign_cnt;

  lvds_link_err_monitor #(
    .WIN_LEN(16), .ERR_THRESH(2), .GOOD_WINS(3), .BAD_WINS(2),
    .MAX_TRAIN_WINS(8), .TOT_W(4)
  ) dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_lane_dpa_done(I_lane_dpa_done),
    .I_error_flag(I_error_flag), .I_clr_cnt(I_clr_cnt),
    .O_link_ok(O_link_ok), .O_realign_req(O_realign_req), .O_state(O_state),
    .O_win_valid(O_win_valid), .O_win_err_cnt(O_win_err_cnt),
    .O_err_total(O_err_total), .O_realign_cnt(O_realign_cnt)
  );

  always #5 I_clk = ~I_clk;

  typedef struct {
    logic       dpa;
    logic       err;
    logic       clr;
    int         n;
    logic [1:0] st;
    logic       ok;
    int         wcnt;
    int         tot;
    int         rcnt;
    int         nvalid;
    int         nreq;
  } step_t;

  step_t tbl[$];
  step_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int valid_seen = 0;
  int req_seen = 0;

  // Pulse counters sampled between the active edge and the driving edge.
  always @(posedge I_clk) begin
    #2;
    if (O_win_valid === 1'b1) valid_seen++;
    if (O_realign_req === 1'b1) req_seen++;
  end

  function automatic void add(int dpa, int err, int clr, int n, int st, int ok,
                              int wcnt, int tot, int rcnt, int nv, int nr);
    step_t s;
    s.dpa = 1'(dpa); s.err = 1'(err); s.clr = 1'(clr); s.n = n;
    s.st = 2'(st); s.ok = 1'(ok); s.wcnt = wcnt; s.tot = tot; s.rcnt = rcnt;
    s.nvalid = nv; s.nreq = nr;
    tbl.push_back(s);
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic run_step(input int idx, input step_t s);
    step_t e;
    exp_q.push_back(s);
    valid_seen = 0;
    req_seen = 0;
    I_lane_dpa_done = s.dpa;
    I_error_flag = s.err;
    I_clr_cnt = s.clr;
    repeat (s.n) @(negedge I_clk);
    e = exp_q.pop_front();
    chk("state", idx, 32'(O_state), 32'(e.st));
    chk("link_ok", idx, 32'(O_link_ok), 32'(e.ok));
    chk("win_err_cnt", idx, 32'(O_win_err_cnt), e.wcnt);
    chk("err_total", idx, 32'(O_err_total), e.tot);
    chk("realign_cnt", idx, 32'(O_realign_cnt), e.rcnt);
    chk("win_valid_pulses", idx, valid_seen, e.nvalid);
    chk("realign_req_pulses", idx, req_seen, e.nreq);
    $display("step %0d: dpa=%0b err=%0b clr=%0b n=%0d -> state=%0d ok=%0b wcnt=%0d tot=%0d rcnt=%0d",
             idx, s.dpa, s.err, s.clr, s.n, O_state, O_link_ok, O_win_err_cnt,
             O_err_total, O_realign_cnt);
  endtask

  initial begin
    int tot_w;
    // Columns: dpa err clr n | state ok wcnt total rcnt valids reqs
    add(1,0,0, 1, 1,0,0, 0,0, 0,0);   // IDLE -> TRAIN
    add(1,0,0,16, 1,0,0, 0,0, 1,0);   // clean window 1
    add(1,0,0,16, 1,0,0, 0,0, 1,0);   // clean window 2
    add(1,0,0,16, 2,1,0, 0,0, 1,0);   // clean window 3 -> LOCKED
    add(1,1,0, 2, 2,1,0, 2,0, 0,0);   // two errors
    add(1,0,0,14, 2,1,2, 2,0, 1,0);   // dirty #1
    add(1,1,0, 2, 2,1,2, 4,0, 0,0);
    add(1,0,0,14, 3,0,2, 4,1, 1,1);   // dirty #2 -> FAULT
    add(1,0,0, 5, 3,0,2, 4,1, 0,0);   // holds FAULT, no extra request
    add(0,0,1, 1, 0,0,2, 0,0, 0,0);   // -> IDLE, clear stats
    add(1,0,0, 1, 1,0,2, 0,0, 0,0);
    add(1,0,0,48, 2,1,0, 0,0, 3,0);   // relock
    add(1,1,0, 2, 2,1,0, 2,0, 0,0);
    add(1,0,0,14, 2,1,2, 2,0, 1,0);   // dirty
    add(1,0,0,16, 2,1,0, 2,0, 1,0);   // clean resets bad count
    add(1,1,0, 1, 2,1,0, 3,0, 0,0);
    add(1,0,0,15, 2,1,1, 3,0, 1,0);   // single error: clean
    add(1,1,0, 2, 2,1,1, 5,0, 0,0);
    add(1,0,0,14, 2,1,2, 5,0, 1,0);   // dirty, still LOCKED
    add(1,1,0, 3, 2,1,2, 8,0, 0,0);
    add(1,0,0,12, 2,1,2, 8,0, 0,0);   // at window cycle 15
    add(0,1,0, 1, 0,0,2, 8,0, 0,0);   // DPA lost on window end
    add(0,1,0, 3, 0,0,2, 8,0, 0,0);   // errors ignored without DPA
    add(1,0,0, 1, 1,0,2, 8,0, 0,0);   // TRAIN, dirty windows follow
    for (int w = 1; w <= 8; w++) begin
      tot_w = (8 + 2 * w > 15) ? 15 : 8 + 2 * w;
      add(1,1,0, 2, 1,0,2, tot_w,0, 0,0);
      add(1,0,0,14, (w == 8) ? 3 : 1, 0, 2, tot_w, (w == 8) ? 1 : 0,
          1, (w == 8) ? 1 : 0);
    end
    add(1,0,0, 3, 3,0,2,15,1, 0,0);
    add(1,0,1, 1, 3,0,2, 0,0, 0,0);   // clear
    add(1,1,0,14, 3,0,2,14,0, 0,0);
    add(1,1,0, 6, 3,0,2,15,0, 0,0);   // saturates after 20 errors
    add(1,1,1, 1, 3,0,2, 0,0, 0,0);   // clear beats coincident error
    add(1,1,0, 1, 3,0,2, 1,0, 0,0);
    add(0,1,0, 1, 0,0,2, 1,0, 0,0);   // FAULT -> IDLE next cycle

    repeat (2) @(negedge I_clk);
    chk("rst_state", 0, 32'(O_state), 0);
    chk("rst_link_ok", 0, 32'(O_link_ok), 0);
    chk("rst_realign_req", 0, 32'(O_realign_req), 0);
    chk("rst_win_valid", 0, 32'(O_win_valid), 0);
    chk("rst_win_err_cnt", 0, 32'(O_win_err_cnt), 0);
    chk("rst_err_total", 0, 32'(O_err_total), 0);
    chk("rst_realign_cnt", 0, 32'(O_realign_cnt), 0);
    I_rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      run_step(i + 1, tbl[i]);
    end

    // Async reset in the middle of a TRAIN window.
    I_lane_dpa_done = 1'b1;
    I_error_flag = 1'b0;
    @(negedge I_clk);
    I_error_flag = 1'b1;
    repeat (5) @(negedge I_clk);
    chk("pre_async_total", 90, 32'(O_err_total), 6);
    I_rst = 1'b0;
    #1;
    chk("async_state", 90, 32'(O_state), 0);
    chk("async_err_total", 90, 32'(O_err_total), 0);
    chk("async_win_err_cnt", 90, 32'(O_win_err_cnt), 0);
    @(negedge I_clk);
    I_error_flag = 1'b0;
    valid_seen = 0;
    req_seen = 0;
    @(negedge I_clk);
    I_rst = 1'b1;
    @(negedge I_clk);
    chk("release_state", 91, 32'(O_state), 1);
    repeat (15) @(negedge I_clk);
    chk("release_no_pulse", 91, valid_seen, 0);
    chk("release_no_req", 91, req_seen, 0);
    @(negedge I_clk);
    chk("fresh_window_valid", 92, valid_seen, 1);
    chk("fresh_window_cnt", 92, 32'(O_win_err_cnt), 0);
    $display("async reset sequence: state=%0d valids=%0d wcnt=%0d",
             O_state, valid_seen, O_win_err_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lvds_link_err_monitor.md
Name: lvds_link_err_monitor

Overview:
Downstream consumer of the per-lane P/N compare error flag.
- Accumulates error cycles over fixed measurement windows while lane DPA is done.
- Qualifies the lane through a TRAIN/LOCKED/FAULT state machine and drives link-OK status.
- Raises a one-cycle re-alignment request to the DPA controller when the link degrades, and keeps saturating error statistics for debug readout.

Parameters:
WIN_LEN, 1024, clock cycles per measurement window (>=2)
ERR_THRESH, 4, window is "dirty" when its error count >= ERR_THRESH (>=1, <=WIN_LEN)
GOOD_WINS, 8, consecutive clean windows in TRAIN needed to reach LOCKED (>=1)
BAD_WINS, 2, consecutive dirty windows in LOCKED that force FAULT (>=1)
MAX_TRAIN_WINS, 64, windows allowed in TRAIN before FAULT (>GOOD_WINS)
TOT_W, 32, width of total error counter

Ports:
I_clk  in  1  system clock
I_rst  in  1  asynchronous reset, active-low
I_lane_dpa_done  in  1  lane phase alignment complete
I_error_flag  in  1  per-cycle P/N mismatch flag, already qualified by dpa_done
I_clr_cnt  in  1  synchronous clear of O_err_total and O_realign_cnt
O_link_ok  out  1  high only in LOCKED
O_realign_req  out  1  one-cycle pulse on FAULT entry
O_state  out  2  IDLE=0, TRAIN=1, LOCKED=2, FAULT=3
O_win_valid  out  1  one-cycle pulse at the end of each window
O_win_err_cnt  out  clog2(WIN_LEN+1)  error count of the last completed window, held between windows
O_err_total  out  TOT_W  saturating count of error cycles
O_realign_cnt  out  8  saturating count of FAULT entries

Behaviour:
- Reset (I_rst=0, async): all outputs 0, state IDLE, all internal counters 0.
- Window counter runs only in TRAIN/LOCKED. It counts 0..WIN_LEN-1; the cycle at WIN_LEN-1 is the window end.
- The window error accumulator adds I_error_flag every active cycle, including the end cycle.
- At window end:
  - O_win_err_cnt and O_win_valid register on the next edge (1-cycle latency).
  - The accumulator restarts at 0, or at 1 if the flag is high in the first cycle of the next window.
- Clean window: count < ERR_THRESH; dirty otherwise.
- IDLE:
  - dpa_done=1 -> TRAIN; window, good, bad and train counters cleared.
- TRAIN:
  - Clean window: good_cnt++; reaching GOOD_WINS -> LOCKED.
  - Dirty window: good_cnt=0.
  - Every window: train_cnt++; reaching MAX_TRAIN_WINS without lock -> FAULT.
  - If lock and timeout occur on the same window end, LOCKED wins.
- LOCKED:
  - Dirty window: bad_cnt++; reaching BAD_WINS -> FAULT.
  - Clean window: bad_cnt=0.
  - O_link_ok is registered and rises on the edge entering LOCKED.
- FAULT:
  - O_realign_req=1 for exactly the first cycle in FAULT; O_realign_cnt++ (saturates at 255).
  - Remain in FAULT until dpa_done=0, then IDLE.
- dpa_done=0 in TRAIN/LOCKED:
  - Next state is IDLE, taking priority over any same-cycle window-end transition.
  - No window-valid pulse is emitted for a partial window; O_link_ok drops the same edge.
- O_err_total:
  - Increments when I_error_flag & I_lane_dpa_done, in any state.
  - Saturates at all-ones, never wraps.
  - I_clr_cnt has priority over increment: counter = 0 that cycle, and that cycle's error is dropped.
- I_error_flag while dpa_done=0 is ignored everywhere.
- Async reset mid-window discards all partial state; no pulse outputs are generated on reset release.

Decomposition:
- Shared package lvds_mon_pkg:
  - State encoding constants (ST_IDLE..ST_FAULT).
  - Default parameter values.
  - clog2 helper function.
- One sub-module, lvds_win_counter: window position counter plus error accumulator. It outputs win_end, win_err_cnt and win_valid. The parent FSM and statistics live in lvds_link_err_monitor.

Test Plan:
All scenarios use WIN_LEN=16, ERR_THRESH=2, GOOD_WINS=3, BAD_WINS=2, MAX_TRAIN_WINS=8.
1. Reset, then dpa_done=1 with no errors for 48 cycles -> O_state 1 then 2; O_link_ok rises after the 3rd O_win_valid; O_win_err_cnt=0.
2. LOCKED, then 2 errors in each of 2 consecutive windows -> FAULT; O_realign_req high exactly 1 cycle; O_realign_cnt=1; O_link_ok=0; O_err_total=4.
3. LOCKED, dirty window, clean window, dirty window -> stays LOCKED (bad_cnt reset by the clean window); single error per window (1<2) never counts as dirty.
4. TRAIN with 2 errors every window for 8 windows -> FAULT on the 8th window end; then dpa_done=0 -> IDLE next cycle.
5. dpa_done drops at window cycle 15 with errors pending -> IDLE; no O_win_valid; O_win_err_cnt keeps its previous value.
6. Force O_err_total near all-ones (TOT_W=4, 20 error cycles) -> holds at 15. Assert I_clr_cnt coincident with an error -> reads 0 next cycle.
